tx_flit_scheduler: RTL and testbench
====================================

// Module: tx_flit_scheduler
// PURPOSE
//   Sequences the single NoC transmit port between three flit buffers: ack buffer, forward (relay) buffer, local send buffer.
//   Pops one flit at a time, holds it, and drives it to the tx link (uart_tx / direct link) with a vld/rdy handshake.
//   Data flits (fwd/loc) stay outstanding until an ack arrives; they are retransmitted on timeout, up to a retry limit.
//   Sits between the flit_buffer instances and the router/checksum/tx stage of the noc top.
// PARAMETERS
//   FLIT_W     128  flit width in bits (matches types::flit_t)
//   TIMEOUT    256  cycles to wait for ack after a data flit handshake; legal range >= 2
//   MAX_RETRY  3    retransmissions allowed per data flit before it is dropped
//   ACK_BURST  4    max consecutive ack grants while a data request is pending
// PORTS
//   nocclk     in   1       NoC clock; all logic is on its rising edge
//   rst        in   1       asynchronous active-high reset
//   ack_vld    in   1       ack buffer non-empty; ack_flit is the head
//   ack_flit   in   FLIT_W  head of ack buffer
//   ack_pop    out  1       one-cycle pop strobe to ack buffer
//   fwd_vld    in   1       forward buffer non-empty
//   fwd_flit   in   FLIT_W  head of forward buffer
//   fwd_pop    out  1       one-cycle pop strobe to forward buffer
//   loc_vld    in   1       local send buffer non-empty
//   loc_flit   in   FLIT_W  head of local send buffer
//   loc_pop    out  1       one-cycle pop strobe to local send buffer
//   tx_flit    out  FLIT_W  flit presented to the router/tx stage
//   tx_vld     out  1       tx_flit valid
//   tx_rdy     in   1       tx stage accepts tx_flit this cycle
//   ack_rcvd   in   1       one-cycle pulse: ack received for the outstanding data flit
//   busy       out  1       state != IDLE
//   grant_src  out  2       0 none, 1 ack, 2 fwd, 3 loc; current holder, 0 in IDLE
//   retry_err  out  1       sticky: a data flit was dropped after MAX_RETRY retries
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0 (tx_flit 0); rr pointer = fwd; burst, timer and retry counters 0; retry_err cleared.
//   Reset mid-operation: the held flit is discarded; no pop and no tx_vld are issued while rst is high.
//   FSM states: IDLE, SEND, WAIT_ACK.
//   IDLE: if any *_vld, grant one source, pulse its *_pop for exactly one cycle, latch its head flit into the hold register, and go to SEND.
//     The flit is sampled in the same cycle as the pop; the buffer head advances after that edge.
//   Arbitration:
//     ack has strict priority, except after ACK_BURST consecutive ack grants with fwd_vld|loc_vld high; then the next grant is data.
//     The burst counter clears on any data grant. It also clears when a grant is made while no data request is pending.
//     Data arbitration is round-robin between fwd and loc. The rr pointer flips to the other source only on a data grant.
//   SEND: tx_vld=1 and tx_flit=hold register, both stable until tx_vld&tx_rdy.
//     On handshake with ack source, go to IDLE.
//     On handshake with data source, go to WAIT_ACK and set timer=0.
//     Latency: pop at cycle N, tx_vld at N+1. Minimum spacing of ack flits is 2 cycles per flit.
//   WAIT_ACK: tx_vld=0; the timer increments each cycle.
//     ack_rcvd: go to IDLE, retry count=0.
//     timer==TIMEOUT-1 without ack, retries<MAX_RETRY: retries++, go to SEND and resend the same hold register, no pop.
//     timer==TIMEOUT-1 without ack, retries==MAX_RETRY: set retry_err, drop the flit, retries=0, go to IDLE.
//     ack_rcvd in the same cycle as the timeout: the ack wins.
//   ack_rcvd outside WAIT_ACK is ignored. New *_vld requests while busy are held off; pops never occur outside IDLE.
//   Widths: timer $clog2(TIMEOUT), retries $clog2(MAX_RETRY+1), burst $clog2(ACK_BURST+1); none of them wrap.
// TESTING
//   loc_vld=1 only, tx_rdy=1 -> loc_pop 1 cycle, tx_vld next cycle with tx_flit=loc_flit; ack_rcvd 10 cycles later -> IDLE, grant_src=0.
//   fwd_vld=loc_vld=1 continuously, ack each flit promptly -> grants alternate fwd,loc,fwd,loc; first grant is fwd after reset.
//   ack_vld=1 and loc_vld=1 held, ACK_BURST=4 -> grant order ack x4, loc, ack x4, loc.
//   tx_rdy=0 for 5 cycles in SEND -> tx_vld and tx_flit stable for all 5 cycles; no *_pop during that time.
//   Data flit, no ack_rcvd, TIMEOUT=8, MAX_RETRY=3 -> 4 transmissions spaced by the timeout; then retry_err=1, IDLE, exactly 1 pop.
//   ack_rcvd in the timeout cycle -> no retransmit; assert rst in SEND -> tx_vld=0 immediately, state IDLE, no pop.

Source files
------------

// File: rtl/tx_flit_scheduler.sv
// Arbitrates ack/forward/local flit buffers onto the single NoC tx port.
// Data flits stay outstanding until acked and are resent on timeout, up to MAX_RETRY times.
module tx_flit_scheduler #(
  parameter int FLIT_W    = 128,
  parameter int TIMEOUT   = 256,
  parameter int MAX_RETRY = 3,
  parameter int ACK_BURST = 4
) (
  input  logic              nocclk,
  input  logic              rst,
  input  logic              ack_vld,
  input  logic [FLIT_W-1:0] ack_flit,
  output logic              ack_pop,
  input  logic              fwd_vld,
  input  logic [FLIT_W-1:0] fwd_flit,
  output logic              fwd_pop,
  input  logic              loc_vld,
  input  logic [FLIT_W-1:0] loc_flit,
  output logic              loc_pop,
  output logic [FLIT_W-1:0] tx_flit,
  output logic              tx_vld,
  input  logic              tx_rdy,
  input  logic              ack_rcvd,
  output logic              busy,
  output logic [1:0]        grant_src,
  output logic              retry_err
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);
  localparam int BST_W = $clog2(ACK_BURST + 1);

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_ACK  = 2'd1;
  localparam logic [1:0] SRC_FWD  = 2'd2;
  localparam logic [1:0] SRC_LOC  = 2'd3;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} state_t;

  state_t             state, next_state;
  logic [FLIT_W-1:0]  hold_q;
  logic [1:0]         src_q;
  logic               rr_loc_q;
  logic [BST_W-1:0]   burst_q;
  logic [TMR_W-1:0]   timer_q;
  logic [RTY_W-1:0]   retry_q;
  logic               retry_err_q;

  logic               data_req;
  logic               burst_full;
  logic               timeout;
  logic [1:0]         sel;
  logic [FLIT_W-1:0]  sel_flit;
  logic               do_grant;
  logic               drop;

  assign data_req   = fwd_vld | loc_vld;
  assign burst_full = (burst_q == BST_W'(ACK_BURST));
  assign timeout    = (timer_q == TMR_W'(TIMEOUT - 1));

  // Ack wins unless its burst allowance is used up while data is waiting.
  always_comb begin
    sel      = SRC_NONE;
    sel_flit = '0;
    if (ack_vld && !(data_req && burst_full)) begin
      sel      = SRC_ACK;
      sel_flit = ack_flit;
    end else if (data_req) begin
      if ((rr_loc_q && loc_vld) || (!rr_loc_q && !fwd_vld)) begin
        sel      = SRC_LOC;
        sel_flit = loc_flit;
      end else begin
        sel      = SRC_FWD;
        sel_flit = fwd_flit;
      end
    end
  end

  always_comb begin
    next_state = state;
    do_grant   = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (sel != SRC_NONE) begin
          do_grant   = 1'b1;
          next_state = SEND;
        end
      end
      SEND: begin
        if (tx_rdy) next_state = (src_q == SRC_ACK) ? IDLE : WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_rcvd) begin
          next_state = IDLE;
        end else if (timeout) begin
          if (retry_q < RTY_W'(MAX_RETRY)) begin
            next_state = SEND;
          end else begin
            next_state = IDLE;
            drop       = 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge nocclk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hold_q      <= '0;
      src_q       <= SRC_NONE;
      rr_loc_q    <= 1'b0;
      burst_q     <= '0;
      timer_q     <= '0;
      retry_q     <= '0;
      retry_err_q <= 1'b0;
    end else begin
      state <= next_state;

      if (do_grant) begin
        hold_q <= sel_flit;
        src_q  <= sel;
        if (sel == SRC_ACK) begin
          burst_q <= data_req ? burst_q + BST_W'(1) : '0;
        end else begin
          burst_q  <= '0;
          rr_loc_q <= (sel == SRC_FWD);
        end
      end

      if (state == SEND && tx_rdy)
        timer_q <= '0;
      else if (state == WAIT_ACK && !timeout)
        timer_q <= timer_q + TMR_W'(1);

      if (state == WAIT_ACK) begin
        if (ack_rcvd)
          retry_q <= '0;
        else if (timeout)
          retry_q <= drop ? '0 : retry_q + RTY_W'(1);
      end

      if (drop) retry_err_q <= 1'b1;
    end
  end

  // Pops are combinational so the head is sampled on the same edge it is consumed.
  assign ack_pop   = do_grant && (sel == SRC_ACK) && !rst;
  assign fwd_pop   = do_grant && (sel == SRC_FWD) && !rst;
  assign loc_pop   = do_grant && (sel == SRC_LOC) && !rst;
  assign tx_vld    = (state == SEND);
  assign tx_flit   = (state == SEND) ? hold_q : '0;
  assign busy      = (state != IDLE);
  assign grant_src = (state == IDLE) ? SRC_NONE : src_q;
  assign retry_err = retry_err_q;

endmodule

// File: tb/tb_tx_flit_scheduler.sv
// Directed bench for tx_flit_scheduler: reset, arbitration order, stall, retry and reset-in-flight.
module tb_tx_flit_scheduler;
  localparam int FW = 32;
  localparam int TMO = 8;
  localparam int MRT = 3;
  localparam int ABR = 4;

  logic          nocclk = 1'b0;
  logic          rst = 1'b1;
  logic          ack_vld = 1'b0, fwd_vld = 1'b0, loc_vld = 1'b0;
  logic [FW-1:0] ack_flit = '0, fwd_flit = '0, loc_flit = '0;
  logic          ack_pop, fwd_pop, loc_pop;
  logic [FW-1:0] tx_flit;
  logic          tx_vld;
  logic          tx_rdy = 1'b0;
  logic          ack_rcvd = 1'b0;
  logic          busy;
  logic [1:0]    grant_src;
  logic          retry_err;

  int vectors = 0;
  int miscompares = 0;

  int cycle = 0;
  int pop_cnt = 0;
  int glog[$];
  int hs_cyc[$];
  logic [FW-1:0] hs_flit[$];

  tx_flit_scheduler #(.FLIT_W(FW), .TIMEOUT(TMO), .MAX_RETRY(MRT), .ACK_BURST(ABR)) dut (
    .nocclk(nocclk), .rst(rst),
    .ack_vld(ack_vld), .ack_flit(ack_flit), .ack_pop(ack_pop),
    .fwd_vld(fwd_vld), .fwd_flit(fwd_flit), .fwd_pop(fwd_pop),
    .loc_vld(loc_vld), .loc_flit(loc_flit), .loc_pop(loc_pop),
    .tx_flit(tx_flit), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
    .ack_rcvd(ack_rcvd), .busy(busy), .grant_src(grant_src), .retry_err(retry_err)
  );

  always #5 nocclk = ~nocclk;

  always @(posedge nocclk) begin
    cycle <= cycle + 1;
    if (ack_pop) glog.push_back(1);
    if (fwd_pop) glog.push_back(2);
    if (loc_pop) glog.push_back(3);
    if (ack_pop || fwd_pop || loc_pop) pop_cnt <= pop_cnt + 1;
    if (tx_vld && tx_rdy) begin
      hs_cyc.push_back(cycle);
      hs_flit.push_back(tx_flit);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ack_vld = 0; fwd_vld = 0; loc_vld = 0; tx_rdy = 0; ack_rcvd = 0;
    repeat (2) @(negedge nocclk);
    rst = 1'b0;
  endtask

  // Acks every data flit the cycle after it enters WAIT_ACK.
  task automatic run_with_acks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge nocclk);
      ack_rcvd = busy && !tx_vld;
    end
    ack_rcvd = 1'b0;
  endtask

  initial begin
    int g0, h0, p0;

    // Reset state, with a request present to show pops are held off.
    loc_vld = 1'b1;
    @(negedge nocclk);
    chk("rst_busy", busy, 0);
    chk("rst_tx_vld", tx_vld, 0);
    chk("rst_tx_flit", tx_flit, 0);
    chk("rst_grant", grant_src, 0);
    chk("rst_err", retry_err, 0);
    chk("rst_pop", loc_pop, 0);
    do_reset();

    // Single local flit, acked 5 cycles after transmission.
    p0 = pop_cnt; h0 = hs_cyc.size();
    loc_flit = 32'hA5A5_0001; loc_vld = 1'b1; tx_rdy = 1'b1;
    #1 chk("t1_pop", loc_pop, 1);
    @(negedge nocclk);
    chk("t1_tx_vld", tx_vld, 1);
    chk("t1_tx_flit", tx_flit, 32'hA5A5_0001);
    chk("t1_grant", grant_src, 3);
    chk("t1_no_pop", loc_pop, 0);
    loc_vld = 1'b0;
    @(negedge nocclk);
    chk("t1_wait_vld", tx_vld, 0);
    chk("t1_wait_busy", busy, 1);
    repeat (4) @(negedge nocclk);
    ack_rcvd = 1'b1;
    @(negedge nocclk);
    ack_rcvd = 1'b0;
    chk("t1_idle", busy, 0);
    chk("t1_grant_idle", grant_src, 0);
    chk("t1_pops", pop_cnt - p0, 1);
    chk("t1_hs", hs_cyc.size() - h0, 1);

    // fwd/loc round-robin, fwd first after reset.
    do_reset();
    g0 = glog.size(); h0 = hs_flit.size();
    fwd_flit = 32'hF0F0_0002; loc_flit = 32'h1C1C_0003;
    fwd_vld = 1'b1; loc_vld = 1'b1; tx_rdy = 1'b1;
    run_with_acks(24);
    fwd_vld = 1'b0; loc_vld = 1'b0;
    run_with_acks(4);
    chk("t2_cnt_ge4", glog.size() - g0 >= 4, 1);
    if (glog.size() - g0 >= 4) begin
      chk("t2_g0", glog[g0], 2);
      chk("t2_g1", glog[g0+1], 3);
      chk("t2_g2", glog[g0+2], 2);
      chk("t2_g3", glog[g0+3], 3);
      chk("t2_f0", hs_flit[h0], 32'hF0F0_0002);
      chk("t2_f1", hs_flit[h0+1], 32'h1C1C_0003);
    end

    // Ack burst limit: ack x4, loc, ack x4, loc.
    do_reset();
    g0 = glog.size();
    ack_flit = 32'hACAC_0004; loc_flit = 32'h1C1C_0005;
    ack_vld = 1'b1; loc_vld = 1'b1; tx_rdy = 1'b1;
    run_with_acks(26);
    ack_vld = 1'b0; loc_vld = 1'b0;
    run_with_acks(4);
    chk("t3_cnt_ge10", glog.size() - g0 >= 10, 1);
    if (glog.size() - g0 >= 10) begin
      for (int i = 0; i < 10; i++)
        chk($sformatf("t3_g%0d", i), glog[g0+i], (i == 4 || i == 9) ? 3 : 1);
    end

    // tx_rdy low for 5 cycles in SEND.
    do_reset();
    p0 = pop_cnt;
    fwd_flit = 32'hBEEF_0006; fwd_vld = 1'b1; tx_rdy = 1'b0;
    #1 chk("t4_pop", fwd_pop, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge nocclk);
      chk($sformatf("t4_vld%0d", i), tx_vld, 1);
      chk($sformatf("t4_flit%0d", i), tx_flit, 32'hBEEF_0006);
      chk($sformatf("t4_nopop%0d", i), fwd_pop, 0);
    end
    tx_rdy = 1'b1; fwd_vld = 1'b0;
    @(negedge nocclk);
    chk("t4_after_hs", tx_vld, 0);
    ack_rcvd = 1'b1;
    @(negedge nocclk);
    ack_rcvd = 1'b0;
    chk("t4_idle", busy, 0);
    chk("t4_pops", pop_cnt - p0, 1);

    // No ack: 4 transmissions TIMEOUT+1 edges apart, then drop.
    do_reset();
    p0 = pop_cnt; h0 = hs_cyc.size();
    loc_flit = 32'hDEAD_0007; loc_vld = 1'b1; tx_rdy = 1'b1;
    @(negedge nocclk);
    loc_vld = 1'b0;
    chk("t5_err_early", retry_err, 0);
    repeat (50) @(negedge nocclk);
    chk("t5_hs", hs_cyc.size() - h0, 4);
    if (hs_cyc.size() - h0 == 4) begin
      for (int i = 1; i < 4; i++)
        chk($sformatf("t5_gap%0d", i), hs_cyc[h0+i] - hs_cyc[h0+i-1], TMO + 1);
      chk("t5_flit_last", hs_flit[h0+3], 32'hDEAD_0007);
    end
    chk("t5_err", retry_err, 1);
    chk("t5_idle", busy, 0);
    chk("t5_pops", pop_cnt - p0, 1);

    // Ack arriving in the timeout cycle wins.
    do_reset();
    h0 = hs_cyc.size();
    loc_flit = 32'h0A0A_0008; loc_vld = 1'b1; tx_rdy = 1'b1;
    @(negedge nocclk);
    loc_vld = 1'b0;
    chk("t6_send", tx_vld, 1);
    @(negedge nocclk);
    chk("t6_wait", busy && !tx_vld, 1);
    repeat (TMO - 1) @(negedge nocclk);
    ack_rcvd = 1'b1;
    @(negedge nocclk);
    ack_rcvd = 1'b0;
    chk("t6_idle", busy, 0);
    repeat (12) @(negedge nocclk);
    chk("t6_hs", hs_cyc.size() - h0, 1);
    chk("t6_err", retry_err, 0);

    // Reset asserted while in SEND.
    do_reset();
    p0 = pop_cnt;
    loc_flit = 32'h5E5E_0009; loc_vld = 1'b1; tx_rdy = 1'b0;
    @(negedge nocclk);
    chk("t7_send", tx_vld, 1);
    #2 rst = 1'b1;
    #1;
    chk("t7_vld_now", tx_vld, 0);
    chk("t7_busy_now", busy, 0);
    chk("t7_nopop", loc_pop, 0);
    @(negedge nocclk);
    chk("t7_pops", pop_cnt - p0, 1);
    loc_vld = 1'b0;
    rst = 1'b0;
    @(negedge nocclk);
    chk("t7_flit", tx_flit, 0);
    chk("t7_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
